win_detector: RTL and testbench

- Consumer side of the board-state interface: watches the panel produced by the game-state FSM and generates the `win` input that FSM consumes.
- On any change of the panel it snapshots the board, then scans it sequentially, one start cell per cycle, for WIN_LEN equal non-empty cells in a line.
- Reports the winner, the winning line, or a draw.
- Sits between the state-update block and the display/top level.

---
 rtl/score4_pkg.sv | 40 ++++
 rtl/line_checker.sv | 69 ++++++
 rtl/win_detector.sv | 168 ++++++++++++++++
 tb/tb_win_detector.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/score4_pkg.sv
`default_nettype none
// ============================================================================
// Module   : score4_pkg
// Purpose  : Shared types and constants for the four-in-a-row board logic:
//            cell encoding, default board geometry, line directions and the
//            win-detector scan FSM states.
// Revision : 1.0 - initial release
// ============================================================================
package score4_pkg;

    typedef logic [1:0] cell_t;

    localparam cell_t CELL_EMPTY = 2'b00;
    localparam cell_t CELL_P0    = 2'b01;
    localparam cell_t CELL_P1    = 2'b10;

    localparam int DEF_COLS    = 7;
    localparam int DEF_ROWS    = 6;
    localparam int DEF_WIN_LEN = 4;

    typedef enum logic [1:0] {
        DIR_H  = 2'd0,
        DIR_V  = 2'd1,
        DIR_D  = 2'd2,
        DIR_AD = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_WIN  = 2'd2
    } state_t;

    // Only 01 and 10 are real pieces; 11 is treated like an empty cell.
    function automatic logic cell_is_player(cell_t c);
        return (c == CELL_P0) || (c == CELL_P1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/line_checker.sv
`default_nettype none
// ============================================================================
// Module   : line_checker
// Purpose  : Combinational test of one start cell: reports whether a line of
//            WIN_LEN equal player cells starts there, in which direction
//            (lowest direction code wins) and with which cell value.
// Revision : 1.0 - initial release
// ============================================================================
module line_checker
    import score4_pkg::*;
#(
    parameter int COLS    = DEF_COLS,
    parameter int ROWS    = DEF_ROWS,
    parameter int WIN_LEN = DEF_WIN_LEN,
    parameter int CW      = (COLS > 1) ? $clog2(COLS) : 1,
    parameter int RW      = (ROWS > 1) ? $clog2(ROWS) : 1
)(
    input  logic [COLS-1:0][ROWS-1:0][1:0] snapshot,
    input  logic [CW-1:0]                  col,
    input  logic [RW-1:0]                  row,
    output logic                           hit,
    output dir_t                           hit_dir,
    output cell_t                          hit_cell
);

    cell_t      w_start;
    logic [3:0] w_dir_hit;

    assign w_start = snapshot[col][row];

    // Walk each direction from the start cell; stepping off the board or onto a different value kills that direction.
    always_comb begin
        int c_i;
        int r_i;
        c_i       = 0;
        r_i       = 0;
        w_dir_hit = '0;
        for (int d = 0; d < 4; d++) begin
            w_dir_hit[d] = cell_is_player(w_start);
            for (int i = 1; i < WIN_LEN; i++) begin
                c_i = int'(col) + ((d == 1) ? 0 : i);
                r_i = int'(row) + ((d == 0) ? 0 : ((d == 3) ? -i : i));
                if ((c_i < 0) || (c_i >= COLS) || (r_i < 0) || (r_i >= ROWS)) begin
                    w_dir_hit[d] = 1'b0;
                end else if (snapshot[c_i[CW-1:0]][r_i[RW-1:0]] != w_start) begin
                    w_dir_hit[d] = 1'b0;
                end
            end
        end
    end

    // Priority select: iterate high to low so the lowest direction code is left standing.
    always_comb begin
        hit      = 1'b0;
        hit_dir  = DIR_H;
        hit_cell = CELL_EMPTY;
        for (int d = 3; d >= 0; d--) begin
            if (w_dir_hit[d]) begin
                hit     = 1'b1;
                hit_dir = dir_t'(d[1:0]);
            end
        end
        if (hit) begin
            hit_cell = w_start;
        end
    end

endmodule
`default_nettype wire

// File: rtl/win_detector.sv
`default_nettype none
// ============================================================================
// Module   : win_detector
// Purpose  : Snapshots the board whenever it changes, scans it one start cell
//            per cycle (column-major) for a winning line, and reports winner,
//            line position/direction, end-of-scan and draw.
// Revision : 1.0 - initial release
// ============================================================================
module win_detector
    import score4_pkg::*;
#(
    parameter int COLS    = DEF_COLS,
    parameter int ROWS    = DEF_ROWS,
    parameter int WIN_LEN = DEF_WIN_LEN
)(
    input  logic                           clk,
    input  logic                           rst,
    input  logic [COLS-1:0][ROWS-1:0][1:0] panel,
    output logic                           busy,
    output logic                           done,
    output logic                           win,
    output logic [1:0]                     winner,
    output logic [2:0]                     win_col,
    output logic [2:0]                     win_row,
    output logic [1:0]                     win_dir,
    output logic                           draw
);

    localparam int CELLS = COLS * ROWS;
    localparam int IW    = (CELLS > 1) ? $clog2(CELLS) : 1;
    localparam int CW    = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;

    state_t                         r_state;
    state_t                         w_state_next;
    logic [COLS-1:0][ROWS-1:0][1:0] r_snapshot;
    logic [IW-1:0]                  r_index;

    logic       r_busy;
    logic       r_done;
    logic       r_win;
    logic [1:0] r_winner;
    logic [2:0] r_win_col;
    logic [2:0] r_win_row;
    logic [1:0] r_win_dir;
    logic       r_draw;

    logic [CW-1:0] w_col;
    logic [RW-1:0] w_row;
    logic          w_hit;
    dir_t          w_hit_dir;
    cell_t         w_hit_cell;
    logic          w_last;
    logic          w_full;
    logic          w_trigger;

    line_checker #(
        .COLS    (COLS),
        .ROWS    (ROWS),
        .WIN_LEN (WIN_LEN),
        .CW      (CW),
        .RW      (RW)
    ) u_line_checker (
        .snapshot (r_snapshot),
        .col      (w_col),
        .row      (w_row),
        .hit      (w_hit),
        .hit_dir  (w_hit_dir),
        .hit_cell (w_hit_cell)
    );

    // Decode the linear scan index into column-major board coordinates.
    always_comb begin
        w_col = CW'(int'(r_index) / ROWS);
        w_row = RW'(int'(r_index) % ROWS);
    end

    assign w_last    = (r_index == IW'(CELLS - 1));
    assign w_trigger = (panel != r_snapshot) && !r_win;

    // Board is full when no cell of the snapshot is empty (or illegal).
    always_comb begin
        w_full = 1'b1;
        for (int c = 0; c < COLS; c++) begin
            for (int r = 0; r < ROWS; r++) begin
                if (!cell_is_player(r_snapshot[c][r])) begin
                    w_full = 1'b0;
                end
            end
        end
    end

    // Next-state logic: a change of panel starts a scan; a hit locks into WIN.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_trigger) w_state_next = ST_SCAN;
            ST_SCAN: begin
                if (w_hit) begin
                    w_state_next = ST_WIN;
                end else if (w_last) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_WIN:  w_state_next = ST_WIN;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // State, snapshot, scan index and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_snapshot <= '0;
            r_index    <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_win      <= 1'b0;
            r_winner   <= 2'b00;
            r_win_col  <= 3'd0;
            r_win_row  <= 3'd0;
            r_win_dir  <= 2'd0;
            r_draw     <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_done  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_trigger) begin
                        r_snapshot <= panel;
                        r_index    <= '0;
                        r_busy     <= 1'b1;
                    end
                end
                ST_SCAN: begin
                    if (w_hit) begin
                        r_win     <= 1'b1;
                        r_winner  <= w_hit_cell;
                        r_win_col <= 3'(w_col);
                        r_win_row <= 3'(w_row);
                        r_win_dir <= w_hit_dir;
                        r_busy    <= 1'b0;
                    end else if (w_last) begin
                        r_busy <= 1'b0;
                        r_done <= 1'b1;
                        if (w_full) begin
                            r_draw <= 1'b1;
                        end
                    end else begin
                        r_index <= r_index + IW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign win     = r_win;
    assign winner  = r_winner;
    assign win_col = r_win_col;
    assign win_row = r_win_row;
    assign win_dir = r_win_dir;
    assign draw    = r_draw;

endmodule
`default_nettype wire

// File: tb/tb_win_detector.sv
`default_nettype none
// ============================================================================
// Module   : tb_win_detector
// Purpose  : Directed self-checking bench for win_detector: idle board, each
//            line direction, scan latency, mid-scan panel change, draw and
//            reset during a scan.
// Revision : 1.0 - initial release
// ============================================================================
module tb_win_detector;
    import score4_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic [6:0][5:0][1:0]  panel = '0;
    logic                  busy;
    logic                  done;
    logic                  win;
    logic [1:0]            winner;
    logic [2:0]            win_col;
    logic [2:0]            win_row;
    logic [1:0]            win_dir;
    logic                  draw;

    int checks = 0;
    int errors = 0;
    int busy_rises = 0;
    logic busy_prev = 1'b0;

    win_detector #(
        .COLS    (7),
        .ROWS    (6),
        .WIN_LEN (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .panel   (panel),
        .busy    (busy),
        .done    (done),
        .win     (win),
        .winner  (winner),
        .win_col (win_col),
        .win_row (win_row),
        .win_dir (win_dir),
        .draw    (draw)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Packed view: {busy, done, win, winner[1:0], win_col[2:0], win_row[2:0], win_dir[1:0], draw}
    function automatic logic [31:0] outs();
        return {18'd0, busy, done, win, winner, win_col, win_row, win_dir, draw};
    endfunction

    function automatic logic [31:0] exp_outs(input logic b, input logic d, input logic w,
                                             input logic [1:0] wn, input logic [2:0] c,
                                             input logic [2:0] r, input logic [1:0] dir,
                                             input logic dr);
        return {18'd0, b, d, w, wn, c, r, dir, dr};
    endfunction

    task automatic put(input logic [2:0] c, input logic [2:0] r, input logic [1:0] v);
        panel[c][r] = v;
    endtask

    task automatic do_reset();
        panel = '0;
        rst   = 1'b0;
        tick();
        tick();
        rst   = 1'b1;
    endtask

    // Full board with no line: value flips with column and with every second row.
    task automatic fill_no_line();
        for (int c = 0; c < 7; c++) begin
            for (int r = 0; r < 6; r++) begin
                put(3'(c), 3'(r), (((c + (r >> 1)) & 1) != 0) ? CELL_P1 : CELL_P0);
            end
        end
    endtask

    initial begin
        // Reset state
        rst = 1'b0;
        tick();
        tick();
        check("reset_outputs", outs(), exp_outs(0, 0, 0, 2'b00, 3'd0, 3'd0, 2'd0, 0));
        rst = 1'b1;

        // Empty board never triggers a scan
        for (int i = 0; i < 100; i++) begin
            tick();
            check("empty_idle", {28'd0, busy, done, win, draw}, 32'd0);
        end

        // Horizontal P0 at row 0, cols 2..5: index 12 -> win 14 cycles after change
        do_reset();
        for (int c = 2; c <= 5; c++) put(3'(c), 3'd0, CELL_P0);
        for (int i = 0; i < 13; i++) tick();
        check("h_win_not_yet", {30'd0, busy, win}, 32'h2);
        tick();
        check("h_win", outs(), exp_outs(0, 0, 1, 2'b01, 3'd2, 3'd0, 2'd0, 0));

        // Vertical P1 at col 6 rows 0..3, P0 filler without a line: index 36
        do_reset();
        for (int r = 0; r <= 3; r++) put(3'd6, 3'(r), CELL_P1);
        for (int r = 0; r <= 2; r++) put(3'd5, 3'(r), CELL_P0);
        for (int i = 0; i < 37; i++) tick();
        check("v_win_not_yet", {31'd0, win}, 32'd0);
        tick();
        check("v_win", outs(), exp_outs(0, 0, 1, 2'b10, 3'd6, 3'd0, 2'd1, 0));
        put(3'd0, 3'd0, CELL_P0);
        put(3'd1, 3'd0, CELL_P1);
        for (int i = 0; i < 50; i++) tick();
        check("v_hold_after_change", outs(), exp_outs(0, 0, 1, 2'b10, 3'd6, 3'd0, 2'd1, 0));

        // Diagonal P0 from (0,0): index 0
        do_reset();
        for (int i = 0; i < 4; i++) put(3'(i), 3'(i), CELL_P0);
        tick();
        tick();
        check("d_win", outs(), exp_outs(0, 0, 1, 2'b01, 3'd0, 3'd0, 2'd2, 0));

        // Anti-diagonal P1 from (1,5): index 11
        do_reset();
        for (int i = 0; i < 4; i++) put(3'(1 + i), 3'(5 - i), CELL_P1);
        for (int i = 0; i < 13; i++) tick();
        check("ad_win", outs(), exp_outs(0, 0, 1, 2'b10, 3'd1, 3'd5, 2'd3, 0));

        // Three in a row, fourth piece added mid-scan: first scan ends without a win
        do_reset();
        for (int c = 0; c <= 2; c++) put(3'(c), 3'd0, CELL_P0);
        busy_rises = 0;
        busy_prev  = 1'b0;
        for (int i = 1; i <= 45; i++) begin
            tick();
            if (busy && !busy_prev) busy_rises++;
            busy_prev = busy;
            if (i == 10) begin
                check("mid_busy", {31'd0, busy}, 32'd1);
                put(3'd3, 3'd0, CELL_P0);
            end
            if (i == 43) check("mid_first_done", outs(), exp_outs(0, 1, 0, 2'b00, 3'd0, 3'd0, 2'd0, 0));
            if (i == 44) check("mid_second_start", outs(), exp_outs(1, 0, 0, 2'b00, 3'd0, 3'd0, 2'd0, 0));
            if (i == 45) check("mid_second_win", outs(), exp_outs(0, 0, 1, 2'b01, 3'd0, 3'd0, 2'd0, 0));
        end
        check("mid_busy_rises", busy_rises, 32'd2);

        // Full board without a line: done pulse with draw
        do_reset();
        fill_no_line();
        for (int i = 0; i < 42; i++) tick();
        check("draw_scanning", {30'd0, busy, done}, 32'h2);
        tick();
        check("draw_done", outs(), exp_outs(0, 1, 0, 2'b00, 3'd0, 3'd0, 2'd0, 1));
        tick();
        check("draw_hold", outs(), exp_outs(0, 0, 0, 2'b00, 3'd0, 3'd0, 2'd0, 1));

        // Reset while scan index is 20
        do_reset();
        fill_no_line();
        for (int i = 0; i < 21; i++) tick();
        check("rst_mid_busy", {31'd0, busy}, 32'd1);
        rst = 1'b0;
        tick();
        check("rst_mid_outputs", outs(), exp_outs(0, 0, 0, 2'b00, 3'd0, 3'd0, 2'd0, 0));
        rst = 1'b1;
        tick();
        check("rst_mid_rescan", {30'd0, busy, done}, 32'h2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
